// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: running status, sysex discard, realtime pass-over,
// channel filter; emits one registered channel-voice message per completion.
//
// state     | meaning
// IDLE      | no running status, data bytes discarded
// WAIT_D1   | running status valid, expecting first data byte
// WAIT_D2   | first data byte held, expecting second
// SYSEX     | inside system exclusive, data bytes discarded
module midi_msg_parser #(
  parameter logic [3:0] DEFAULT_CHAN = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_dv,
  input  logic [7:0] rx_data,
  input  logic       omni,
  input  logic [3:0] chan_sel,
  output logic       msg_v,
  output logic [2:0] msg_type,
  output logic [3:0] msg_ch,
  output logic [6:0] msg_d1,
  output logic [6:0] msg_d2,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_D1 = 2'd1,
    S_WAIT_D2 = 2'd2,
    S_SYSEX   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] rs_type_q, rs_type_d;
  logic [3:0] rs_ch_q, rs_ch_d;
  logic [6:0] d1_q, d1_d;
  logic       fresh_q, fresh_d;

  logic       msg_v_q, msg_v_d;
  logic [2:0] msg_type_q, msg_type_d;
  logic [3:0] msg_ch_q, msg_ch_d;
  logic [6:0] msg_d1_q, msg_d1_d;
  logic [6:0] msg_d2_q, msg_d2_d;
  logic       busy_d;

  logic       is_data, is_status, is_sysex, is_common;
  logic       one_byte;
  logic       complete;
  logic [6:0] cpl_d1, cpl_d2;

  // Realtime bytes (F8-FF) match none of these and fall through untouched.
  always_comb begin
    is_data   = rx_dv & ~rx_data[7];
    is_status = rx_dv & rx_data[7] & (rx_data[7:4] != 4'hF);
    is_sysex  = rx_dv & (rx_data == 8'hF0);
    is_common = rx_dv & (rx_data[7:3] == 5'b11110) & (rx_data[2:0] != 3'd0);
    one_byte  = (rs_type_q == 3'd4) | (rs_type_q == 3'd5);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rs_type_q  <= 3'd0;
      rs_ch_q    <= DEFAULT_CHAN;
      d1_q       <= 7'd0;
      fresh_q    <= 1'b0;
      msg_v_q    <= 1'b0;
      msg_type_q <= 3'd0;
      msg_ch_q   <= 4'd0;
      msg_d1_q   <= 7'd0;
      msg_d2_q   <= 7'd0;
    end else begin
      state_q    <= state_d;
      rs_type_q  <= rs_type_d;
      rs_ch_q    <= rs_ch_d;
      d1_q       <= d1_d;
      fresh_q    <= fresh_d;
      msg_v_q    <= msg_v_d;
      msg_type_q <= msg_type_d;
      msg_ch_q   <= msg_ch_d;
      msg_d1_q   <= msg_d1_d;
      msg_d2_q   <= msg_d2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rs_type_d = rs_type_q;
    rs_ch_d   = rs_ch_q;
    d1_d      = d1_q;
    fresh_d   = fresh_q;
    complete  = 1'b0;
    cpl_d1    = d1_q;
    cpl_d2    = 7'd0;

    if (is_status) begin
      state_d   = S_WAIT_D1;
      rs_type_d = rx_data[6:4];
      rs_ch_d   = rx_data[3:0];
      fresh_d   = 1'b1;
    end else if (is_sysex || is_common) begin
      state_d   = is_sysex ? S_SYSEX : S_IDLE;
      rs_type_d = 3'd0;
      rs_ch_d   = DEFAULT_CHAN;
      fresh_d   = 1'b0;
    end else if (is_data) begin
      case (state_q)
        S_WAIT_D1: begin
          if (one_byte) begin
            complete = 1'b1;
            cpl_d1   = rx_data[6:0];
            cpl_d2   = 7'd0;
            fresh_d  = 1'b0;
          end else begin
            d1_d    = rx_data[6:0];
            state_d = S_WAIT_D2;
          end
        end
        S_WAIT_D2: begin
          complete = 1'b1;
          cpl_d1   = d1_q;
          cpl_d2   = rx_data[6:0];
          fresh_d  = 1'b0;
          state_d  = S_WAIT_D1;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Filtered messages still advance the parser but leave the outputs alone.
  always_comb begin
    msg_v_d    = 1'b0;
    msg_type_d = msg_type_q;
    msg_ch_d   = msg_ch_q;
    msg_d1_d   = msg_d1_q;
    msg_d2_d   = msg_d2_q;
    if (complete && (omni || (rs_ch_q == chan_sel))) begin
      msg_v_d    = 1'b1;
      msg_type_d = ((rs_type_q == 3'd1) && (cpl_d2 == 7'd0)) ? 3'd0 : rs_type_q;
      msg_ch_d   = rs_ch_q;
      msg_d1_d   = cpl_d1;
      msg_d2_d   = cpl_d2;
    end
    busy_d = (state_q == S_WAIT_D2) || ((state_q == S_WAIT_D1) && fresh_q);
  end

  assign msg_v    = msg_v_q;
  assign msg_type = msg_type_q;
  assign msg_ch   = msg_ch_q;
  assign msg_d1   = msg_d1_q;
  assign msg_d2   = msg_d2_q;
  assign busy     = busy_d;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: byte-level reference model checked every cycle,
// plus literal expectations per directed scenario.
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_data;
  logic       omni;
  logic [3:0] chan_sel;
  logic       msg_v;
  logic [2:0] msg_type;
  logic [3:0] msg_ch;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;
  logic       busy;

  midi_msg_parser #(.DEFAULT_CHAN(4'd0)) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_data(rx_data),
    .omni(omni), .chan_sel(chan_sel),
    .msg_v(msg_v), .msg_type(msg_type), .msg_ch(msg_ch),
    .msg_d1(msg_d1), .msg_d2(msg_d2), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: running status as plain flags and fields.
  logic       m_rs, m_have, m_fresh;
  logic [2:0] m_type;
  logic [3:0] m_ch;
  logic [6:0] m_d1;
  logic       e_v;
  logic [2:0] e_type;
  logic [3:0] e_ch;
  logic [6:0] e_d1, e_d2;

  wire       m_cpl = rx_dv && !rx_data[7] && m_rs &&
                     (m_type == 3'd4 || m_type == 3'd5 || m_have);
  wire [6:0] c_d1  = m_have ? m_d1 : rx_data[6:0];
  wire [6:0] c_d2  = m_have ? rx_data[6:0] : 7'd0;
  wire [2:0] c_t   = (m_type == 3'd1 && c_d2 == 7'd0) ? 3'd0 : m_type;
  wire       e_busy = m_rs && (m_have || m_fresh);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rs <= 0; m_have <= 0; m_fresh <= 0; m_type <= 0; m_ch <= 0; m_d1 <= 0;
      e_v <= 0; e_type <= 0; e_ch <= 0; e_d1 <= 0; e_d2 <= 0;
    end else begin
      e_v <= 1'b0;
      if (rx_dv) begin
        if (rx_data >= 8'hF8) begin
        end else if (rx_data >= 8'hF0) begin
          m_rs <= 0; m_have <= 0; m_fresh <= 0;
        end else if (rx_data >= 8'h80) begin
          m_rs <= 1; m_have <= 0; m_fresh <= 1;
          m_type <= rx_data[6:4]; m_ch <= rx_data[3:0];
        end else if (m_cpl) begin
          m_have <= 0; m_fresh <= 0;
          if (omni || m_ch == chan_sel) begin
            e_v <= 1; e_type <= c_t; e_ch <= m_ch; e_d1 <= c_d1; e_d2 <= c_d2;
          end
        end else if (m_rs) begin
          m_have <= 1; m_d1 <= rx_data[6:0];
        end
      end
    end
  end

  int         pulses = 0;
  logic [2:0] l_type;
  logic [3:0] l_ch;
  logic [6:0] l_d1, l_d2;

  always @(negedge clk) begin
    cmp("msg_v", msg_v, e_v);
    cmp("msg_type", msg_type, e_type);
    cmp("msg_ch", msg_ch, e_ch);
    cmp("msg_d1", msg_d1, e_d1);
    cmp("msg_d2", msg_d2, e_d2);
    cmp("busy", busy, e_busy);
    if (msg_v) begin
      pulses++;
      l_type = msg_type; l_ch = msg_ch; l_d1 = msg_d1; l_d2 = msg_d2;
    end
  end

  logic [7:0] seq[$];

  task automatic play(input bit b2b);
    while (seq.size() > 0) begin
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_data = seq.pop_front();
      if (!b2b) begin
        @(negedge clk);
        rx_dv = 1'b0;
      end
    end
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic check_last(input string nm, input int np, input int t, input int ch,
                            input int d1, input int d2);
    cmp({nm, "_pulses"}, pulses, np);
    cmp({nm, "_type"}, l_type, t);
    cmp({nm, "_ch"}, l_ch, ch);
    cmp({nm, "_d1"}, l_d1, d1);
    cmp({nm, "_d2"}, l_d2, d2);
  endtask

  initial begin
    rst = 1'b0; rx_dv = 1'b0; rx_data = 8'h00; omni = 1'b1; chan_sel = 4'd0;
    l_type = 0; l_ch = 0; l_d1 = 0; l_d2 = 0;
    repeat (2) @(negedge clk);
    #1;
    cmp("rst_msg_v", msg_v, 0);
    cmp("rst_busy", busy, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // 1: basic note on
    pulses = 0;
    seq = '{8'h90, 8'h3C, 8'h64}; play(0);
    check_last("t1", 1, 1, 0, 'h3C, 'h64);

    // 2: running status, velocity-0 note on, back-to-back bytes
    pulses = 0;
    seq = '{8'h91, 8'h3C, 8'h64, 8'h3E, 8'h00}; play(1);
    check_last("t2", 2, 0, 1, 'h3E, 'h00);
    cmp("t2_busy_rs", busy, 0);

    // 3: realtime interleave
    pulses = 0;
    seq = '{8'h90, 8'hF8}; play(0);
    cmp("t3_busy_rt", busy, 1);
    seq = '{8'h40, 8'hFE, 8'h7F}; play(0);
    check_last("t3", 1, 1, 0, 'h40, 'h7F);

    // 4: program change running status
    pulses = 0;
    seq = '{8'hC5, 8'h0A}; play(0);
    check_last("t4a", 1, 4, 5, 'h0A, 0);
    seq = '{8'h0B}; play(0);
    check_last("t4b", 2, 4, 5, 'h0B, 0);

    // 5: sysex and system common
    pulses = 0;
    seq = '{8'h90, 8'hF0, 8'h01, 8'h02, 8'hF7, 8'h40, 8'h41}; play(1);
    cmp("t5a_pulses", pulses, 0);
    seq = '{8'hB0, 8'h07, 8'hF2, 8'h10}; play(0);
    cmp("t5b_pulses", pulses, 0);
    cmp("t5b_busy", busy, 0);
    seq = '{8'h11, 8'h12}; play(0);
    cmp("t5b_idle_pulses", pulses, 0);

    // 6: channel filter
    omni = 1'b0; chan_sel = 4'd2;
    pulses = 0;
    seq = '{8'h93, 8'h40, 8'h50}; play(0);
    cmp("t6a_pulses", pulses, 0);
    seq = '{8'h92, 8'h40, 8'h50}; play(0);
    check_last("t6b", 1, 1, 2, 'h40, 'h50);
    omni = 1'b1; chan_sel = 4'd0;

    // 6: reset mid-message
    pulses = 0;
    seq = '{8'h90, 8'h3C}; play(0);
    cmp("t6c_busy_pre", busy, 1);
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    cmp("t6c_rst_v", msg_v, 0);
    cmp("t6c_rst_type", msg_type, 0);
    cmp("t6c_rst_ch", msg_ch, 0);
    cmp("t6c_rst_d1", msg_d1, 0);
    cmp("t6c_rst_d2", msg_d2, 0);
    cmp("t6c_rst_busy", busy, 0);
    rst = 1'b1;
    seq = '{8'h40}; play(0);
    cmp("t6c_pulses", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
